// File: rtl/brick_field_scorer.sv
// brick_field_scorer: brick bitmap, remaining-brick count and saturating score
// for the breakout playfield. Accepts one ball-hit query at a time
// (valid/ready) and answers it two cycles after acceptance with hit_done.
// Optional feature macro: COMBO_MULT_EN (combo score multiplier, reset by
// paddle_touch). Without it every brick is worth BRICK_POINTS and combo is 0.
module brick_field_scorer #(
  parameter int ROWS         = 7,
  parameter int COLS         = 16,
  parameter int BRICK_W      = 2,
  parameter int ROW_W        = 4,
  parameter int COL_W        = 4,
  parameter int SCORE_W      = 10,
  parameter int BRICK_POINTS = 1,
  parameter int COMBO_MAX    = 4,
  localparam int BPR         = COLS / BRICK_W,
  localparam int NB          = ROWS * BPR,
  localparam int CNT_W       = $clog2(NB + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               hit_valid,
  output logic               hit_ready,
  input  logic [ROW_W-1:0]   hit_row,
  input  logic [COL_W-1:0]   hit_col,
  input  logic               paddle_touch,
  input  logic               level_load,
  output logic [NB-1:0]      bricks,
  output logic [SCORE_W-1:0] score,
  output logic [CNT_W-1:0]   bricks_left,
  output logic               level_clear,
  output logic               hit_done,
  output logic               hit_brick,
  output logic [2:0]         combo
);

  localparam int    IDX_W     = (NB > 1) ? $clog2(NB) : 1;
  localparam longint SCORE_MAX = (longint'(1) << SCORE_W) - 1;

  typedef enum logic [1:0] {IDLE, CHECK, UPDATE} state_t;

  state_t             state_q;
  logic [NB-1:0]      bricks_q;
  logic [SCORE_W-1:0] score_q;
  logic [CNT_W-1:0]   bricks_left_q;
  logic               level_clear_q;
  logic               hit_done_q;
  logic               hit_brick_q;
  logic [ROW_W-1:0]   row_q;
  logic [COL_W-1:0]   col_q;
  logic [IDX_W-1:0]   idx_q;
  logic               present_q;

  logic               in_range_d;
  logic [IDX_W-1:0]   idx_d;
  logic               present_d;
  int                 pts_d;

  // Score addition that clamps at the all-ones value instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input int pts);
    longint sum;
    sum = longint'(a) + longint'(pts);
    return (sum > SCORE_MAX) ? '1 : sum[SCORE_W-1:0];
  endfunction

`ifdef COMBO_MULT_EN
  logic [2:0] combo_q;
  assign combo = combo_q;
`else
  logic unused_ok;
  assign combo     = 3'd0;
  assign unused_ok = paddle_touch ^ (COMBO_MAX > 0);
`endif

  assign hit_ready   = (state_q == IDLE) && !level_clear_q;
  assign bricks      = bricks_q;
  assign score       = score_q;
  assign bricks_left = bricks_left_q;
  assign level_clear = level_clear_q;
  assign hit_done    = hit_done_q;
  assign hit_brick   = hit_brick_q;

  // Map the captured ball position onto a bitmap index; off-field positions are misses.
  always_comb begin
    int row_v;
    int col_v;
    row_v      = int'(row_q);
    col_v      = int'(col_q);
    in_range_d = (row_v >= 1) && (row_v <= ROWS) && (col_v < COLS);
    idx_d      = in_range_d ? IDX_W'((row_v - 1) * BPR + col_v / BRICK_W) : '0;
    present_d  = in_range_d && bricks_q[idx_d];
`ifdef COMBO_MULT_EN
    pts_d      = BRICK_POINTS * (int'(combo_q) + 1);
`else
    pts_d      = BRICK_POINTS;
`endif
  end

  // Query FSM plus all field/score state; level_load overrides everything but reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      bricks_q      <= '1;
      score_q       <= '0;
      bricks_left_q <= CNT_W'(NB);
      level_clear_q <= 1'b0;
      hit_done_q    <= 1'b0;
      hit_brick_q   <= 1'b0;
`ifdef COMBO_MULT_EN
      combo_q       <= 3'd0;
`endif
    end else begin
      hit_done_q <= 1'b0;
`ifdef COMBO_MULT_EN
      if (paddle_touch) combo_q <= 3'd0;
`endif
      if (level_load) begin
        state_q       <= IDLE;
        bricks_q      <= '1;
        bricks_left_q <= CNT_W'(NB);
        level_clear_q <= 1'b0;
`ifdef COMBO_MULT_EN
        combo_q       <= 3'd0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (hit_valid && hit_ready) begin
              row_q   <= hit_row;
              col_q   <= hit_col;
              state_q <= CHECK;
            end
          end
          CHECK: begin
            present_q <= present_d;
            idx_q     <= idx_d;
            state_q   <= UPDATE;
          end
          UPDATE: begin
            hit_done_q  <= 1'b1;
            hit_brick_q <= present_q;
            if (present_q) begin
              bricks_q[idx_q] <= 1'b0;
              bricks_left_q   <= bricks_left_q - CNT_W'(1);
              score_q         <= sat_add(score_q, pts_d);
              if (bricks_left_q == CNT_W'(1)) level_clear_q <= 1'b1;
`ifdef COMBO_MULT_EN
              if (!paddle_touch && (combo_q < 3'(COMBO_MAX - 1)))
                combo_q <= combo_q + 3'd1;
`endif
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_brick_field_scorer.sv
// Directed bench for brick_field_scorer: a default instance (u0) and a
// SCORE_W=4 / COL_W=5 instance (u1) share the same stimulus.
module tb_brick_field_scorer;

  logic        clock = 1'b0;
  logic        reset, hit_valid, paddle_touch, level_load;
  logic [3:0]  hit_row;
  logic [4:0]  hit_col5;

  logic        rdy0, lc0, done0, hb0;
  logic [55:0] bricks0;
  logic [9:0]  score0;
  logic [5:0]  left0;
  logic [2:0]  combo0;

  logic        rdy1, lc1, done1, hb1;
  logic [55:0] bricks1;
  logic [3:0]  score1;
  logic [5:0]  left1;
  logic [2:0]  combo1;

  int checks = 0;
  int errors = 0;
  int s0, s1, l0, l1;

  localparam logic [63:0] ALL56 = 64'h00FF_FFFF_FFFF_FFFF;

  brick_field_scorer u0 (
    .clock(clock), .reset(reset), .hit_valid(hit_valid), .hit_ready(rdy0),
    .hit_row(hit_row), .hit_col(hit_col5[3:0]), .paddle_touch(paddle_touch),
    .level_load(level_load), .bricks(bricks0), .score(score0),
    .bricks_left(left0), .level_clear(lc0), .hit_done(done0),
    .hit_brick(hb0), .combo(combo0)
  );

  brick_field_scorer #(.SCORE_W(4), .COL_W(5)) u1 (
    .clock(clock), .reset(reset), .hit_valid(hit_valid), .hit_ready(rdy1),
    .hit_row(hit_row), .hit_col(hit_col5), .paddle_touch(paddle_touch),
    .level_load(level_load), .bricks(bricks1), .score(score1),
    .bricks_left(left1), .level_clear(lc1), .hit_done(done1),
    .hit_brick(hb1), .combo(combo1)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full query; e0/e1 = expected hit_brick per instance, rd = expected
  // hit_ready in the hit_done cycle, pt = paddle_touch sampled at the UPDATE edge.
  task automatic hit(input logic [3:0] r, input logic [4:0] c,
                     input logic e0, input logic e1, input logic rd, input logic pt);
    int n = 0;
    while (!rdy0 && n < 20) begin tick(); n++; end
    chk("ready_wait", rdy0, 1);
    hit_row = r; hit_col5 = c; hit_valid = 1'b1;
    tick();
    hit_valid = 1'b0;
    chk("done_n0", done0, 0);
    chk("busy_n0", rdy0, 0);
    tick();
    chk("done_n1", done0, 0);
    paddle_touch = pt;
    tick();
    paddle_touch = 1'b0;
    chk("done_n2", done0, 1);
    chk("brick0", hb0, e0);
    chk("done1_n2", done1, 1);
    chk("brick1", hb1, e1);
    chk("ready_n2", rdy0, rd);
    chk("ready1_n2", rdy1, rd);
    tick();
    chk("done_pulse", done0, 0);
  endtask

  initial begin
    reset = 1'b1; hit_valid = 1'b0; paddle_touch = 1'b0; level_load = 1'b0;
    hit_row = '0; hit_col5 = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_bricks", bricks0, ALL56);
    chk("rst_score", score0, 0);
    chk("rst_left", left0, 56);
    chk("rst_lc", lc0, 0);
    chk("rst_done", done0, 0);
    chk("rst_hb", hb0, 0);
    chk("rst_combo", combo0, 0);
    reset = 1'b0;
    tick();
    chk("rst_ready", rdy0, 1);

    // first brick, then same brick again (and same brick via its other column)
    hit(4'd1, 5'd0, 1, 1, 1, 0);
    chk("t1_bit0", bricks0[0], 0);
    chk("t1_score", score0, 1);
    chk("t1_left", left0, 55);
    hit(4'd1, 5'd0, 0, 0, 1, 0);
    hit(4'd1, 5'd1, 0, 0, 1, 0);
    chk("t2_score", score0, 1);
    chk("t2_left", left0, 55);

    // off-field queries; u0 sees col 16 truncated to col 0 of row 2
    hit(4'd0, 5'd3, 0, 0, 1, 0);
    hit(4'd8, 5'd3, 0, 0, 1, 0);
    chk("t3_left", left0, 55);
    hit(4'd2, 5'd16, 1, 0, 1, 0);
    chk("t3_u1_score", score1, 1);
    chk("t3_u1_left", left1, 55);
    chk("t3_u0_left", left0, 54);

    // clear the whole field; u1 score saturates at 15
    s0 = 2; s1 = 1; l0 = 54; l1 = 55;
    for (int r = 1; r <= 7; r++) begin
      for (int b = 0; b < 8; b++) begin
        int  idx;
        logic e0, e1;
        idx = (r - 1) * 8 + b;
        e0  = !(idx == 0 || idx == 8);
        e1  = (idx != 0);
        hit(4'(r), 5'(b * 2 + 1), e0, e1, idx != 55, 0);
        s0 += int'(e0); l0 -= int'(e0); l1 -= int'(e1);
        s1 = (s1 + int'(e1) > 15) ? 15 : s1 + int'(e1);
        chk("clr_score0", score0, s0);
        chk("clr_score1", score1, s1);
        chk("clr_left0", left0, l0);
        chk("clr_left1", left1, l1);
      end
    end
    chk("t5_lc", lc0, 1);
    chk("t5_lc1", lc1, 1);
    chk("t5_ready", rdy0, 0);
    chk("t5_bricks", bricks0, 0);

    // queries are refused while the level is clear
    hit_row = 4'd1; hit_col5 = 5'd0; hit_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); chk("lc_nodone", done0, 0); end
    hit_valid = 1'b0;

    // reload keeps score
    level_load = 1'b1;
    tick();
    level_load = 1'b0;
    chk("ld_bricks", bricks0, ALL56);
    chk("ld_bricks1", bricks1, ALL56);
    chk("ld_left", left0, 56);
    chk("ld_lc", lc0, 0);
    chk("ld_ready", rdy0, 1);
    chk("ld_score0", score0, 56);
    chk("ld_score1", score1, 15);

    // level_load wins over a same-cycle accept
    hit_valid = 1'b1; level_load = 1'b1;
    tick();
    hit_valid = 1'b0; level_load = 1'b0;
    chk("ldacc_ready", rdy0, 1);
    for (int i = 0; i < 3; i++) begin tick(); chk("ldacc_nodone", done0, 0); end
    chk("ldacc_bricks", bricks0, ALL56);

    // level_load while the query is in CHECK drops it
    hit_valid = 1'b1;
    tick();
    hit_valid = 1'b0;
    chk("ldchk_busy", rdy0, 0);
    level_load = 1'b1;
    tick();
    level_load = 1'b0;
    chk("ldchk_ready", rdy0, 1);
    for (int i = 0; i < 3; i++) begin tick(); chk("ldchk_nodone", done0, 0); end
    chk("ldchk_bricks", bricks0, ALL56);
    chk("ldchk_score", score0, 56);

    // reset mid-query aborts it
    hit_valid = 1'b1;
    tick();
    hit_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); chk("rstq_nodone", done0, 0); end
    chk("rstq_score", score0, 0);
    chk("rstq_score1", score1, 0);
    chk("rstq_left", left0, 56);
    chk("rstq_ready", rdy0, 1);

`ifdef COMBO_MULT_EN
    begin
      int exp_sc[5] = '{1, 3, 6, 10, 14};
      int exp_cb[5] = '{1, 2, 3, 3, 3};
      for (int k = 0; k < 5; k++) begin
        hit(4'd3, 5'(k * 2), 1, 1, 1, 0);
        chk("cmb_score", score0, exp_sc[k]);
        chk("cmb_combo", combo0, exp_cb[k]);
        chk("cmb_score1", score1, exp_sc[k] > 15 ? 15 : exp_sc[k]);
      end
    end
    paddle_touch = 1'b1;
    tick();
    paddle_touch = 1'b0;
    chk("cmb_pt_clear", combo0, 0);
    chk("cmb_pt_clear1", combo1, 0);
    hit(4'd3, 5'd10, 1, 1, 1, 0);
    chk("cmb_after_pt", score0, 15);
    chk("cmb_after_combo", combo0, 1);
    hit(4'd3, 5'd12, 1, 1, 1, 1);
    chk("cmb_pt_upd_score", score0, 17);
    chk("cmb_pt_upd_combo", combo0, 0);
    chk("cmb_pt_upd_score1", score1, 15);
`else
    hit(4'd3, 5'd0, 1, 1, 1, 0);
    chk("nc_score", score0, 1);
    chk("nc_combo", combo0, 0);
    paddle_touch = 1'b1;
    tick();
    paddle_touch = 1'b0;
    hit(4'd3, 5'd2, 1, 1, 1, 1);
    chk("nc_score2", score0, 2);
    chk("nc_combo2", combo0, 0);
    chk("nc_combo2_u1", combo1, 0);
    chk("nc_score2_u1", score1, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
